jtkicker_objscan: RTL and testbench
===================================

# jtkicker_objscan

Object line scanner that feeds `jtkicker_objdraw`. At the start of every line it walks the object attribute RAM, selects the objects that intersect the next line, and issues one `draw` request per hit. Each request carries x position, row within the object, palette, flips and tile code, and waits on the draw stage's `busy`. It sits between the CPU-shared object RAM and the object line buffer.

## Interface
- `OBJ_N`, default 24: number of objects scanned (1..64).
- `VOFFSET`, default 8'd1: added to `vdump` to form the line being prepared.
- `clk`  in  1  48 MHz system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `cen2`  in  1  clock enable; all state advances only on `cen2`.
- `hinit_x`  in  1  line start strobe, sampled on `cen2`.
- `vdump`  in  8  current video line.
- `obj_addr`  out  8  object RAM byte address `{index[5:0], byte[1:0]}`.
- `obj_dout`  in  8  object RAM data, valid on the `clk` edge after `obj_addr` changes.
- `draw`  out  1  draw request to the draw stage.
- `busy`  in  1  draw stage busy.
- `xpos`  out  8  object x.
- `ysub`  out  4  row within the 16-line object.
- `pal`  out  4  palette.
- `hflip`, `vflip`  out  1 each  flips.
- `code`  out  9  tile code.
- `done`  out  1  high once the current line's scan is complete.

## Operation
- Object record, 4 bytes: byte0 = y, byte1 = code[7:0], byte2 = {unused, code[8], vflip, hflip, pal[3:0]}, byte3 = x.
- Scan order: index OBJ_N-1 down to 0. Index 0 is drawn last, so it wins priority in the line buffer.
- States: IDLE, READ, CHECK, DRAW, WAIT.
- IDLE
  - `done`=1.
  - On `hinit_x`: latch `line = vdump + VOFFSET` (8-bit wrap), set index = OBJ_N-1, byte = 0, clear `done`, go to READ.
- READ
  - One byte per `cen2`. Present `{index, byte}` on `obj_addr`; capture `obj_dout` on the following `cen2`.
  - Four captures: y, code low, attr, x. Then go to CHECK.
- CHECK
  - `ydiff = line - y`, 8-bit modulo.
  - Hit when `ydiff[7:4]==0`. On a hit, `ysub = ydiff[3:0]`; the draw stage applies `vflip` itself. Go to DRAW.
  - On a miss, go to NEXT handling.
- DRAW
  - Drive all data outputs and `draw`=1.
  - On a `cen2` with `busy`=0, the request is taken: go to WAIT and drop `draw`.
  - If `busy`=1, hold `draw` and data unchanged.
- WAIT
  - `draw`=0. When `busy`=0 on a `cen2`, do NEXT handling.
- NEXT handling
  - If index==0: go to IDLE and set `done`.
  - Otherwise: decrement index, byte = 0, go to READ.
- Data outputs stay stable from DRAW entry until the next DRAW entry.
- `hinit_x` outside IDLE aborts the scan: latch the new line, restart at index OBJ_N-1 in READ, drop `draw`, clear `done`. The next DRAW still waits for `busy`=0, so an in-flight draw completes undisturbed.
- `hinit_x` coinciding with the `cen2` that would accept a request: the abort wins and no request is taken.

## Timing
- Reset values: `draw`=0, `done`=1, `obj_addr`=0, `xpos`=0, `ysub`=0, `pal`=0, `hflip`=0, `vflip`=0, `code`=0. State = IDLE.
- Reset mid-scan returns to IDLE immediately (asynchronous). `draw` falls without waiting for a `cen2`.
- A missed object costs 5 `cen2` cycles (4 READ + CHECK).
- A hit costs 5 `cen2` cycles + 1 DRAW + the draw stage's busy time.
- `draw` rises on the `cen2` edge that leaves CHECK.
- The draw stage sets `busy` on the same `cen2` it accepts, so WAIT always observes `busy`=1 on its first `cen2`.
- `obj_addr` changes only on `cen2`. The RAM has one full `clk` period of latency, which must be well under one `cen2` period.
- `done` rises on the `cen2` after the last WAIT/CHECK of index 0.

## Test plan
- Empty scene: all y=8'hF0, vdump=8'd10 -> zero `draw` pulses; `done` high 5·OBJ_N `cen2` after `hinit_x`.
- Single hit: obj 3 y=8'd20, code=9'h1A5, attr=8'h5C, x=8'd100; vdump=8'd24 -> one `draw` with xpos=100, ysub=5, pal=C, hflip=1, vflip=0, code=1A5.
- Y wrap: y=8'd250, vdump=8'd3 (line 4) -> hit with ysub=10. Boundary: y=8'd250, line 10 -> miss (ydiff=16).
- Ordering and handshake: objs 0, 7, 23 all hit; model `busy` for 18 `cen2` -> draws issued in order 23, 7, 0. Each request waits for `busy` low; data stays stable while `draw`=1.
- Abort: `hinit_x` while WAITing on obj 12 with `busy`=1 -> rescan starts at index 23. No new `draw` until `busy` falls. `line` = new vdump+1.
- Reset: `rst_n` low while `draw`=1 -> `draw`=0 and `done`=1 without any `clk` edge; after release, the block idles until `hinit_x`.

Source files
------------

// File: rtl/jtkicker_objscan.sv
// Object line scanner: walks object RAM at each line start and issues one
// draw request per object intersecting the line being prepared.
module jtkicker_objscan #(
  parameter int         OBJ_N   = 24,
  parameter logic [7:0] VOFFSET = 8'd1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cen2,
  input  logic       hinit_x,
  input  logic [7:0] vdump,
  output logic [7:0] obj_addr,
  input  logic [7:0] obj_dout,
  output logic       draw,
  input  logic       busy,
  output logic [7:0] xpos,
  output logic [3:0] ysub,
  output logic [3:0] pal,
  output logic       hflip,
  output logic       vflip,
  output logic [8:0] code,
  output logic       done
);

  typedef enum logic [2:0] {IDLE, READ, CHECK, DRAW, WAIT} state_t;

  localparam logic [5:0] LAST_IDX = 6'(OBJ_N - 1);

  state_t      state, state_nxt;
  logic [5:0]  idx;
  logic [1:0]  bsel;
  logic [7:0]  line;
  logic [7:0]  y_r, codel_r, x_r;
  logic [6:0]  attr_r;
  logic [7:0]  ydiff;
  logic        hit, last, next_obj;

  always_comb begin
    ydiff    = line - y_r;
    hit      = (ydiff[7:4] == 4'd0);
    last     = (idx == 6'd0);
    next_obj = (state == CHECK && !hit) || (state == WAIT && !busy);
    state_nxt = state;
    if (hinit_x) begin
      state_nxt = READ;
    end else begin
      case (state)
        READ:    if (bsel == 2'd3) state_nxt = CHECK;
        CHECK:   if (hit) state_nxt = DRAW;
                 else     state_nxt = last ? IDLE : READ;
        DRAW:    if (!busy) state_nxt = WAIT;
        WAIT:    if (!busy) state_nxt = last ? IDLE : READ;
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    state <= IDLE;
    else if (cen2) state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx      <= '0;
      bsel     <= '0;
      line     <= '0;
      y_r      <= '0;
      codel_r  <= '0;
      attr_r   <= '0;
      x_r      <= '0;
      obj_addr <= '0;
      draw     <= 1'b0;
      done     <= 1'b1;
      xpos     <= '0;
      ysub     <= '0;
      pal      <= '0;
      hflip    <= 1'b0;
      vflip    <= 1'b0;
      code     <= '0;
    end else if (cen2) begin
      if (hinit_x) begin
        // Restart from any state; output data is left alone so an in-flight
        // draw keeps its values until the next request is presented.
        line     <= vdump + VOFFSET;
        idx      <= LAST_IDX;
        bsel     <= '0;
        obj_addr <= {LAST_IDX, 2'd0};
        draw     <= 1'b0;
        done     <= 1'b0;
      end else begin
        case (state)
          READ: begin
            case (bsel)
              2'd0:    y_r     <= obj_dout;
              2'd1:    codel_r <= obj_dout;
              2'd2:    attr_r  <= obj_dout[6:0];
              default: x_r     <= obj_dout;
            endcase
            if (bsel != 2'd3) begin
              bsel     <= bsel + 2'd1;
              obj_addr <= {idx, bsel + 2'd1};
            end
          end
          CHECK: if (hit) begin
            xpos  <= x_r;
            ysub  <= ydiff[3:0];
            pal   <= attr_r[3:0];
            hflip <= attr_r[4];
            vflip <= attr_r[5];
            code  <= {attr_r[6], codel_r};
            draw  <= 1'b1;
          end
          DRAW: if (!busy) draw <= 1'b0;
          default: ;
        endcase
        if (next_obj) begin
          if (last) begin
            done <= 1'b1;
          end else begin
            idx      <= idx - 6'd1;
            bsel     <= '0;
            obj_addr <= {idx - 6'd1, 2'd0};
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_jtkicker_objscan.sv
// Directed bench for jtkicker_objscan with a registered RAM and draw-stage model.
module tb_jtkicker_objscan;

  localparam int OBJ_N = 24;

  logic       clk = 1'b0, rst_n = 1'b0, hinit_x = 1'b0;
  logic       cen2, busy;
  logic [7:0] vdump = 8'd0, obj_addr, obj_dout = 8'd0;
  logic       draw, hflip, vflip, done;
  logic [7:0] xpos;
  logic [3:0] ysub, pal;
  logic [8:0] code;

  jtkicker_objscan #(.OBJ_N(OBJ_N), .VOFFSET(8'd1)) dut (
    .clk(clk), .rst_n(rst_n), .cen2(cen2), .hinit_x(hinit_x), .vdump(vdump),
    .obj_addr(obj_addr), .obj_dout(obj_dout), .draw(draw), .busy(busy),
    .xpos(xpos), .ysub(ysub), .pal(pal), .hflip(hflip), .vflip(vflip),
    .code(code), .done(done)
  );

  always #5 clk = ~clk;

  logic [1:0] cnt = 2'd0;
  always @(posedge clk) cnt <= cnt + 2'd1;
  assign cen2 = (cnt == 2'd3);

  logic [7:0] mem [256];
  always @(posedge clk) obj_dout <= mem[obj_addr];

  // draw stage: busy rises on the accepting cen2 and lasts busy_len cen2 edges
  int   busy_len = 3;
  int   bcnt = 0;
  logic busy_m = 1'b0, busy_man = 1'b0;
  assign busy = busy_m | busy_man;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_m <= 1'b0;
      bcnt   <= 0;
    end else if (cen2) begin
      if (draw && !busy && !hinit_x) begin
        busy_m <= 1'b1;
        bcnt   <= busy_len;
      end else if (busy_m) begin
        if (bcnt <= 1) busy_m <= 1'b0;
        else           bcnt   <= bcnt - 1;
      end
    end
  end

  // request monitor: predicts acceptance on the coming edge, checks stability
  int         acc_n = 0, hold_n = 0, stab_err = 0;
  logic [8:0] acc_code [$];
  logic [26:0] snap = '0;
  logic       draw_q = 1'b0;
  always @(negedge clk) begin
    if (rst_n && cen2 && draw && !busy && !hinit_x) begin
      acc_n <= acc_n + 1;
      acc_code.push_back(code);
    end
    if (draw && busy) hold_n <= hold_n + 1;
    if (draw && draw_q && {xpos, ysub, pal, hflip, vflip, code} != snap)
      stab_err <= stab_err + 1;
    snap   <= {xpos, ysub, pal, hflip, vflip, code};
    draw_q <= draw;
  end

  int errors = 0, checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step_cen(input int n);
    repeat (n) begin
      do @(negedge clk); while (!cen2);
      @(negedge clk);
    end
  endtask

  task automatic pulse_hinit(input logic [7:0] v);
    do @(negedge clk); while (!cen2);
    vdump   = v;
    hinit_x = 1'b1;
    @(negedge clk);
    hinit_x = 1'b0;
  endtask

  task automatic wait_done(output int n, input int lim);
    n = 0;
    while (!done && n < lim) begin
      step_cen(1);
      n++;
    end
    if (!done) check("done_timeout", 32'(done), 32'd1);
  endtask

  task automatic clear_scene;
    for (int i = 0; i < 64; i++) begin
      mem[i*4]   = 8'hF0;
      mem[i*4+1] = 8'h00;
      mem[i*4+2] = 8'h00;
      mem[i*4+3] = 8'h00;
    end
  endtask

  task automatic set_obj(input int idx, input logic [7:0] y, input logic [7:0] cl,
                         input logic [7:0] attr, input logic [7:0] x);
    mem[idx*4]   = y;
    mem[idx*4+1] = cl;
    mem[idx*4+2] = attr;
    mem[idx*4+3] = x;
  endtask

  typedef struct {
    logic [7:0] y, cl, attr, x, vd;
    int         hits;
    logic [3:0] ysub, pal;
    logic       hf, vf;
    logic [8:0] code;
  } vec_t;

  vec_t tbl [7];

  initial begin
    int n, base, h0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    tbl[0] = '{8'd20,  8'hA5, 8'h5C, 8'd100, 8'd24, 1, 4'd5,  4'hC, 1'b1, 1'b0, 9'h1A5};
    tbl[1] = '{8'd250, 8'h12, 8'h23, 8'd7,   8'd3,  1, 4'd10, 4'h3, 1'b0, 1'b1, 9'h012};
    tbl[2] = '{8'd250, 8'h12, 8'h23, 8'd7,   8'd9,  0, 4'd0,  4'h0, 1'b0, 1'b0, 9'h000};
    tbl[3] = '{8'd20,  8'h00, 8'h7F, 8'd255, 8'd19, 1, 4'd0,  4'hF, 1'b1, 1'b1, 9'h100};
    tbl[4] = '{8'd20,  8'hFF, 8'h80, 8'd0,   8'd34, 1, 4'd15, 4'h0, 1'b0, 1'b0, 9'h0FF};
    tbl[5] = '{8'd20,  8'hFF, 8'h80, 8'd0,   8'd35, 0, 4'd0,  4'h0, 1'b0, 1'b0, 9'h000};
    tbl[6] = '{8'd30,  8'h11, 8'h00, 8'd9,   8'd28, 0, 4'd0,  4'h0, 1'b0, 1'b0, 9'h000};

    // reset state
    repeat (3) @(negedge clk);
    check("rst_draw", 32'(draw), 32'd0);
    check("rst_done", 32'(done), 32'd1);
    check("rst_addr", 32'(obj_addr), 32'd0);
    check("rst_data", 32'({xpos, ysub, pal, hflip, vflip, code}), 32'd0);
    rst_n = 1'b1;
    clear_scene();

    // empty scene: done after 5*OBJ_N cen2, no requests
    base = acc_n;
    pulse_hinit(8'd10);
    check("empty_done_low", 32'(done), 32'd0);
    wait_done(n, 1000);
    check("empty_cycles", 32'(n), 32'(5 * OBJ_N));
    check("empty_draws", 32'(acc_n - base), 32'd0);

    // single-object vectors on object 3
    for (int i = 0; i < 7; i++) begin
      clear_scene();
      set_obj(3, tbl[i].y, tbl[i].cl, tbl[i].attr, tbl[i].x);
      base = acc_n;
      pulse_hinit(tbl[i].vd);
      wait_done(n, 1000);
      check($sformatf("v%0d_draws", i), 32'(acc_n - base), 32'(tbl[i].hits));
      if (tbl[i].hits != 0) begin
        check($sformatf("v%0d_xpos", i),  32'(xpos),  32'(tbl[i].x));
        check($sformatf("v%0d_ysub", i),  32'(ysub),  32'(tbl[i].ysub));
        check($sformatf("v%0d_pal", i),   32'(pal),   32'(tbl[i].pal));
        check($sformatf("v%0d_hflip", i), 32'(hflip), 32'(tbl[i].hf));
        check($sformatf("v%0d_vflip", i), 32'(vflip), 32'(tbl[i].vf));
        check($sformatf("v%0d_code", i),  32'(code),  32'(tbl[i].code));
      end
    end

    // ordering with 18-cen2 busy
    clear_scene();
    set_obj(0,  8'd20, 8'd0,  8'h00, 8'd0);
    set_obj(7,  8'd20, 8'd7,  8'h00, 8'd70);
    set_obj(23, 8'd20, 8'd23, 8'h00, 8'd230);
    busy_len = 18;
    base = acc_n;
    pulse_hinit(8'd24);
    wait_done(n, 2000);
    check("order_count", 32'(acc_n - base), 32'd3);
    if (acc_n - base == 3) begin
      check("order_0", 32'(acc_code[base]),     32'd23);
      check("order_1", 32'(acc_code[base + 1]), 32'd7);
      check("order_2", 32'(acc_code[base + 2]), 32'd0);
    end
    busy_len = 3;

    // request held under external busy, then abort coinciding with acceptance
    clear_scene();
    set_obj(3, 8'd20, 8'h33, 8'h02, 8'd55);
    busy_man = 1'b1;
    base = acc_n;
    pulse_hinit(8'd24);
    step_cen(110);
    check("hold_draw", 32'(draw), 32'd1);
    h0 = hold_n;
    step_cen(10);
    check("hold_draw_still", 32'(draw), 32'd1);
    check("hold_cycles", 32'((hold_n - h0) > 0), 32'd1);
    check("hold_xpos", 32'(xpos), 32'd55);
    check("hold_not_taken", 32'(acc_n - base), 32'd0);
    do @(negedge clk); while (!cen2);
    busy_man = 1'b0;
    hinit_x  = 1'b1;
    vdump    = 8'd24;
    @(negedge clk);
    hinit_x = 1'b0;
    check("abort_take_draw", 32'(draw), 32'd0);
    check("abort_take_addr", 32'(obj_addr), 32'h5C);
    check("abort_take_cnt", 32'(acc_n - base), 32'd0);
    wait_done(n, 1000);
    check("abort_take_redraw", 32'(acc_n - base), 32'd1);

    // abort while WAITing on object 12
    clear_scene();
    set_obj(12, 8'd20, 8'h0C, 8'h00, 8'd12);
    busy_len = 200;
    base = acc_n;
    pulse_hinit(8'd24);
    n = 0;
    while ((acc_n - base) < 1 && n < 200) begin step_cen(1); n++; end
    step_cen(2);
    check("wait12_taken", 32'(acc_n - base), 32'd1);
    check("wait12_busy", 32'(busy), 32'd1);
    set_obj(23, 8'd20, 8'h17, 8'h01, 8'd23);
    pulse_hinit(8'd30);
    check("abort_draw", 32'(draw), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_addr", 32'(obj_addr), 32'h5C);
    step_cen(6);
    check("abort_redraw", 32'(draw), 32'd1);
    check("abort_ysub", 32'(ysub), 32'd11);
    check("abort_code", 32'(code), 32'h017);
    check("abort_wait_busy", 32'(acc_n - base), 32'd1);

    // asynchronous reset while draw is high
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("arst_draw", 32'(draw), 32'd0);
    check("arst_done", 32'(done), 32'd1);
    check("arst_data", 32'({obj_addr, xpos, code}), 32'd0);
    repeat (3) @(negedge clk);
    rst_n    = 1'b1;
    busy_len = 3;
    base = acc_n;
    step_cen(40);
    check("post_rst_done", 32'(done), 32'd1);
    check("post_rst_idle", 32'({draw, obj_addr}), 32'd0);
    pulse_hinit(8'd24);
    wait_done(n, 1000);
    check("post_rst_scan", 32'(acc_n - base), 32'd2);

    check("stable_data", 32'(stab_err), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
